// File: rtl/player_move_ctrl.sv
// Player movement sequencer: key edges -> collision query -> draw handshake -> exit/map advance.
// Optional build macro MOVE_REPEAT_EN adds held-key auto-repeat every REPEAT_TICKS cycles.
module player_move_ctrl #(
  parameter logic [4:0]  START_X      = 5'd0,
  parameter logic [4:0]  START_Y      = 5'd8,
  parameter logic [4:0]  EXIT_X       = 5'd14,
  parameter logic [4:0]  EXIT_Y       = 5'd13,
  parameter logic [1:0]  LAST_MAP     = 2'd3,
  parameter logic [23:0] REPEAT_TICKS = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic [4:0] cd_new_x,
  input  logic [4:0] cd_new_y,
  output logic [4:0] cd_cur_x,
  output logic [4:0] cd_cur_y,
  output logic [2:0] cd_move,
  output logic [1:0] cd_map,
  output logic [4:0] pos_x,
  output logic [4:0] pos_y,
  output logic [1:0] map_sel,
  output logic [4:0] old_x,
  output logic [4:0] old_y,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic       level_done,
  output logic       game_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_SAMPLE, S_DRAW, S_CHECK, S_LEVEL, S_DONE
  } state_t;

  localparam logic [2:0] MV_NONE  = 3'b000;
  localparam logic [2:0] MV_UP    = 3'b001;
  localparam logic [2:0] MV_LEFT  = 3'b010;
  localparam logic [2:0] MV_DOWN  = 3'b011;
  localparam logic [2:0] MV_RIGHT = 3'b100;

  state_t     r_state;
  logic [3:0] r_key;
  logic [2:0] r_dir;
  logic [4:0] r_pos_x, r_pos_y, r_old_x, r_old_y;
  logic [1:0] r_map;
  logic       r_draw_req, r_level_done, r_game_done, r_busy;

  logic [3:0] w_keys, w_rise;
  logic [2:0] w_edge_dir, w_req;
  logic       w_at_exit;

  assign w_keys    = {key_up, key_down, key_left, key_right};
  assign w_rise    = w_keys & ~r_key;
  assign w_at_exit = (r_pos_x == EXIT_X) && (r_pos_y == EXIT_Y);

  always_comb begin
    w_edge_dir = MV_NONE;
    if (w_rise[3])      w_edge_dir = MV_UP;
    else if (w_rise[2]) w_edge_dir = MV_DOWN;
    else if (w_rise[1]) w_edge_dir = MV_LEFT;
    else if (w_rise[0]) w_edge_dir = MV_RIGHT;
  end

`ifdef MOVE_REPEAT_EN
  logic [23:0] r_rep_cnt;
  logic [2:0]  r_rep_dir;
  logic        w_held, w_rep_fire;

  always_comb begin
    w_held = 1'b0;
    case (r_rep_dir)
      MV_UP:    w_held = key_up;
      MV_DOWN:  w_held = key_down;
      MV_LEFT:  w_held = key_left;
      MV_RIGHT: w_held = key_right;
      default:  w_held = 1'b0;
    endcase
  end

  assign w_rep_fire = (r_state == S_IDLE) && w_held && (r_rep_cnt == 24'd0)
                      && (w_rise == 4'b0000);
  assign w_req      = (w_edge_dir != MV_NONE) ? w_edge_dir
                    : (w_rep_fire ? r_rep_dir : MV_NONE);

  // Down-counter only advances in IDLE; terminal count re-issues the held direction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rep_cnt <= REPEAT_TICKS - 24'd1;
      r_rep_dir <= MV_NONE;
    end else if (!w_held) begin
      r_rep_cnt <= REPEAT_TICKS - 24'd1;
      if (r_state == S_IDLE && w_edge_dir != MV_NONE) r_rep_dir <= w_edge_dir;
    end else if (r_state == S_IDLE) begin
      if (w_rise != 4'b0000) begin
        r_rep_cnt <= REPEAT_TICKS - 24'd1;
        r_rep_dir <= w_edge_dir;
      end else if (r_rep_cnt == 24'd0) begin
        r_rep_cnt <= REPEAT_TICKS - 24'd1;
      end else begin
        r_rep_cnt <= r_rep_cnt - 24'd1;
      end
    end
  end
`else
  assign w_req = w_edge_dir;

  // Edge-only build: the repeat interval has no hardware behind it.
  if (REPEAT_TICKS == 24'd0) begin : g_no_repeat
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_key        <= 4'b0000;
      r_dir        <= MV_NONE;
      r_pos_x      <= START_X;
      r_pos_y      <= START_Y;
      r_old_x      <= START_X;
      r_old_y      <= START_Y;
      r_map        <= 2'd0;
      r_draw_req   <= 1'b0;
      r_level_done <= 1'b0;
      r_game_done  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_key        <= w_keys;
      r_level_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req != MV_NONE) begin
            r_dir   <= w_req;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_SAMPLE;
        // Detector output is valid here because cd_move is still driven.
        S_SAMPLE: begin
          r_dir <= MV_NONE;
          if (cd_new_x == r_pos_x && cd_new_y == r_pos_y) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_old_x    <= r_pos_x;
            r_old_y    <= r_pos_y;
            r_pos_x    <= cd_new_x;
            r_pos_y    <= cd_new_y;
            r_draw_req <= 1'b1;
            r_state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (draw_ack) begin
            r_draw_req <= 1'b0;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_at_exit && r_map == LAST_MAP) begin
            r_game_done <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_at_exit) begin
            r_state <= S_LEVEL;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_LEVEL: begin
          r_map        <= r_map + 2'd1;
          r_pos_x      <= START_X;
          r_pos_y      <= START_Y;
          r_old_x      <= EXIT_X;
          r_old_y      <= EXIT_Y;
          r_level_done <= 1'b1;
          r_draw_req   <= 1'b1;
          r_state      <= S_DRAW;
        end
        S_DONE:  r_state <= S_DONE;
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cd_move    = r_dir;
  assign cd_cur_x   = r_pos_x;
  assign cd_cur_y   = r_pos_y;
  assign cd_map     = r_map;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign map_sel    = r_map;
  assign old_x      = r_old_x;
  assign old_y      = r_old_y;
  assign draw_req   = r_draw_req;
  assign level_done = r_level_done;
  assign game_done  = r_game_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: stub detector on a 32x32 grid plus a
// position/map reference model driven by random and directed key presses.
module tb_player_move_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [4:0] cd_new_x, cd_new_y, cd_cur_x, cd_cur_y;
  logic [2:0] cd_move;
  logic [1:0] cd_map, map_sel;
  logic [4:0] pos_x, pos_y, old_x, old_y;
  logic       draw_req, draw_ack = 1'b0, level_done, game_done, busy;

  bit tb_wall = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int lvl_pulses = 0;

  // reference model state
  int m_x, m_y, m_ox, m_oy, m_map;
  bit m_done;

  player_move_ctrl dut (
    .clk(clk), .resetn(resetn),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .cd_new_x(cd_new_x), .cd_new_y(cd_new_y), .cd_cur_x(cd_cur_x), .cd_cur_y(cd_cur_y),
    .cd_move(cd_move), .cd_map(cd_map), .pos_x(pos_x), .pos_y(pos_y), .map_sel(map_sel),
    .old_x(old_x), .old_y(old_y), .draw_req(draw_req), .draw_ack(draw_ack),
    .level_done(level_done), .game_done(game_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (level_done === 1'b1) lvl_pulses++;

  // Stub detector: single step, blocked by tb_wall or by leaving the 32x32 grid.
  always_comb begin
    int nx, ny;
    nx = int'(cd_cur_x);
    ny = int'(cd_cur_y);
    case (cd_move)
      3'b001:  ny = ny - 1;
      3'b011:  ny = ny + 1;
      3'b010:  nx = nx - 1;
      3'b100:  nx = nx + 1;
      default: ;
    endcase
    if (tb_wall || nx < 0 || nx > 31 || ny < 0 || ny > 31) begin
      nx = int'(cd_cur_x);
      ny = int'(cd_cur_y);
    end
    cd_new_x = nx[4:0];
    cd_new_y = ny[4:0];
  end

  function automatic logic [2:0] enc(input int d);
    case (d)
      0: return 3'b001;
      1: return 3'b011;
      2: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic set_key(input int d, input logic v);
    case (d)
      0: key_up = v;
      1: key_down = v;
      2: key_left = v;
      default: key_right = v;
    endcase
  endtask

  task automatic do_reset();
    key_up = 0; key_down = 0; key_left = 0; key_right = 0; draw_ack = 0; tb_wall = 0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    m_x = 0; m_y = 8; m_ox = 0; m_oy = 8; m_map = 0; m_done = 0;
  endtask

  // Press direction d for one step; the detector is walled if 'wall'; ack after ack_dly cycles.
  task automatic apply_move(input int d, input bit wall, input int ack_dly);
    int tx, ty;
    bit blk, at_exit;
    tx = m_x; ty = m_y;
    case (d)
      0: ty = ty - 1;
      1: ty = ty + 1;
      2: tx = tx - 1;
      default: tx = tx + 1;
    endcase
    blk = m_done || wall || tx < 0 || tx > 31 || ty < 0 || ty > 31;
    tb_wall = wall;
    @(negedge clk); set_key(d, 1'b1);
    @(posedge clk); #1;
    n_vec++;
    if (cd_move !== (m_done ? 3'b000 : enc(d)) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL issue: cd_move=%b busy=%b, expected cd_move=%b busy=1",
               cd_move, busy, m_done ? 3'b000 : enc(d));
    end
    @(posedge clk); #1;
    if (!m_done) begin
      n_vec++;
      if (cd_move !== enc(d) || draw_req !== 1'b0) begin
        n_err++;
        $display("FAIL sample: cd_move=%b draw_req=%b, expected %b / 0", cd_move, draw_req, enc(d));
      end
    end
    @(posedge clk); #1;
    if (blk) begin
      n_vec++;
      if (draw_req !== 1'b0 || busy !== m_done || game_done !== m_done ||
          int'(pos_x) != m_x || int'(pos_y) != m_y || cd_move !== 3'b000) begin
        n_err++;
        $display("FAIL blocked: draw_req=%b busy=%b pos=(%0d,%0d), expected 0 %0d (%0d,%0d)",
                 draw_req, busy, pos_x, pos_y, m_done, m_x, m_y);
      end
    end else begin
      m_ox = m_x; m_oy = m_y; m_x = tx; m_y = ty;
      n_vec++;
      if (draw_req !== 1'b1 || int'(pos_x) != m_x || int'(pos_y) != m_y ||
          int'(old_x) != m_ox || int'(old_y) != m_oy || int'(cd_cur_x) != m_x ||
          int'(cd_cur_y) != m_y || cd_move !== 3'b000) begin
        n_err++;
        $display("FAIL step: req=%b pos=(%0d,%0d) old=(%0d,%0d), expected 1 (%0d,%0d) (%0d,%0d)",
                 draw_req, pos_x, pos_y, old_x, old_y, m_x, m_y, m_ox, m_oy);
      end
    end
    @(negedge clk); set_key(d, 1'b0);
    if (!blk) begin
      if (ack_dly == 0) draw_ack = 1'b1;
      else begin
        repeat (ack_dly) begin
          @(posedge clk); #1;
          n_vec++;
          if (draw_req !== 1'b1) begin
            n_err++;
            $display("FAIL req_hold: draw_req=%b, expected 1", draw_req);
          end
        end
        @(negedge clk); draw_ack = 1'b1;
      end
      @(posedge clk); #1;
      draw_ack = 1'b0;
      n_vec++;
      if (draw_req !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL ack: draw_req=%b busy=%b, expected 0 1", draw_req, busy);
      end
      at_exit = (m_x == 14 && m_y == 13);
      @(posedge clk); #1;
      if (!at_exit) begin
        n_vec++;
        if (busy !== 1'b0 || level_done !== 1'b0 || game_done !== 1'b0 || int'(map_sel) != m_map) begin
          n_err++;
          $display("FAIL check_idle: busy=%b level_done=%b map=%0d, expected 0 0 %0d",
                   busy, level_done, map_sel, m_map);
        end
      end else if (m_map == 3) begin
        m_done = 1;
        n_vec++;
        if (game_done !== 1'b1 || busy !== 1'b1 || level_done !== 1'b0) begin
          n_err++;
          $display("FAIL game_done: game_done=%b busy=%b, expected 1 1", game_done, busy);
        end
      end else begin
        @(posedge clk); #1;
        m_map++; m_x = 0; m_y = 8; m_ox = 14; m_oy = 13;
        n_vec++;
        if (level_done !== 1'b1 || int'(map_sel) != m_map || int'(cd_map) != m_map ||
            int'(pos_x) != 0 || int'(pos_y) != 8 || int'(old_x) != 14 || int'(old_y) != 13 ||
            draw_req !== 1'b1) begin
          n_err++;
          $display("FAIL level: ld=%b map=%0d pos=(%0d,%0d) old=(%0d,%0d) req=%b, expected 1 %0d (0,8) (14,13) 1",
                   level_done, map_sel, pos_x, pos_y, old_x, old_y, draw_req, m_map);
        end
        @(negedge clk); draw_ack = 1'b1;
        @(posedge clk); #1;
        draw_ack = 1'b0;
        n_vec++;
        if (level_done !== 1'b0 || draw_req !== 1'b0) begin
          n_err++;
          $display("FAIL level_pulse: level_done=%b draw_req=%b, expected 0 0", level_done, draw_req);
        end
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || int'(pos_x) != 0 || int'(pos_y) != 8) begin
          n_err++;
          $display("FAIL level_idle: busy=%b pos=(%0d,%0d), expected 0 (0,8)", busy, pos_x, pos_y);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if (pos_x !== 5'd0 || pos_y !== 5'd8 || old_x !== 5'd0 || old_y !== 5'd8 ||
        map_sel !== 2'd0 || cd_move !== 3'b000 || draw_req !== 1'b0 ||
        level_done !== 1'b0 || game_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset: pos=(%0d,%0d) map=%0d mv=%b req=%b ld=%b gd=%b busy=%b, expected (0,8) 0 000 0 0 0 0",
               pos_x, pos_y, map_sel, cd_move, draw_req, level_done, game_done, busy);
    end
  endtask

  task automatic test_open_step();
    apply_move(3, 1'b0, 4);
    apply_move(1, 1'b0, 0);
    apply_move(3, 1'b0, 2);
  endtask

  task automatic test_wall();
    apply_move(0, 1'b1, 0);
    apply_move(3, 1'b1, 0);
    apply_move(2, 1'b0, 1);
    apply_move(2, 1'b0, 0);
    apply_move(2, 1'b0, 0);  // x=0 border, detector refuses
  endtask

  task automatic test_priority();
    @(negedge clk); key_up = 1'b1; key_left = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (cd_move !== 3'b001) begin
      n_err++;
      $display("FAIL priority: cd_move=%b, expected 001", cd_move);
    end
    repeat (2) @(posedge clk);
    #1;
    m_oy = m_y; m_ox = m_x; m_y = m_y - 1;
    n_vec++;
    if (draw_req !== 1'b1 || int'(pos_x) != m_x || int'(pos_y) != m_y) begin
      n_err++;
      $display("FAIL priority_step: req=%b pos=(%0d,%0d), expected 1 (%0d,%0d)", draw_req, pos_x, pos_y, m_x, m_y);
    end
    @(negedge clk); key_up = 1'b0; key_left = 1'b0;
    @(negedge clk); key_down = 1'b1;
    repeat (2) @(negedge clk);
    draw_ack = 1'b1;
    @(posedge clk); #1;
    draw_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (busy !== 1'b0 || cd_move !== 3'b000 || int'(pos_y) != m_y) begin
        n_err++;
        $display("FAIL ignored_edge: busy=%b cd_move=%b pos_y=%0d, expected 0 000 %0d", busy, cd_move, pos_y, m_y);
      end
    end
    @(negedge clk); key_down = 1'b0;
  endtask

  task automatic test_random_walk();
    for (int i = 0; i < 40; i++)
      apply_move($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
  endtask

  task automatic test_level_progression();
    int start_pulses, guard;
    do_reset();
    start_pulses = lvl_pulses;
    guard = 0;
    while (!m_done && guard < 200) begin
      if (m_x < 14)      apply_move(3, 1'b0, $urandom_range(0, 2));
      else if (m_x > 14) apply_move(2, 1'b0, $urandom_range(0, 2));
      else if (m_y < 13) apply_move(1, 1'b0, $urandom_range(0, 2));
      else               apply_move(0, 1'b0, $urandom_range(0, 2));
      guard++;
    end
    n_vec++;
    if (lvl_pulses - start_pulses != 3 || game_done !== 1'b1 || map_sel !== 2'd3) begin
      n_err++;
      $display("FAIL progression: level pulses=%0d game_done=%b map=%0d, expected 3 1 3",
               lvl_pulses - start_pulses, game_done, map_sel);
    end
    apply_move(2, 1'b0, 0);
    apply_move(0, 1'b0, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    apply_move(3, 1'b0, 1);
    @(negedge clk); key_down = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (draw_req !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: draw_req=%b, expected 1", draw_req);
    end
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if (draw_req !== 1'b0 || pos_x !== 5'd0 || pos_y !== 5'd8 || old_x !== 5'd0 ||
        old_y !== 5'd8 || busy !== 1'b0 || map_sel !== 2'd0) begin
      n_err++;
      $display("FAIL async_reset: req=%b pos=(%0d,%0d) busy=%b, expected 0 (0,8) 0", draw_req, pos_x, pos_y, busy);
    end
    key_down = 1'b0;
    @(negedge clk); resetn = 1'b1;
    m_x = 0; m_y = 8; m_ox = 0; m_oy = 8; m_map = 0; m_done = 0;
    apply_move(1, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_open_step();
    test_wall();
    test_priority();
    test_random_walk();
    test_level_progression();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
